id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V pipeline. It captures the instruction decoder's control bundle together with the ID-stage operands and presents them to EX one cycle later. It compares the ID instruction's source registers against a load currently in EX, inserts a bubble when they collide, and tells the PC and IF/ID register to hold. It also applies EX-stage redirect flushes and an external freeze, and keeps a saturating count of inserted load-use bubbles.

## Interface
- No parameters; datapath width is fixed at 32 bits and register addresses at 5 bits.
- CLK  in  1  rising-edge clock; one clock domain.
- RSTn  in  1  asynchronous active-low reset.
- valid_id  in  1  ID holds a real, legal instruction. ID drives 0 for illegal opcodes.
- pc_id, rs1_data_id, rs2_data_id, imm_id  in  32 each  ID operands.
- rs1_addr_id, rs2_addr_id, rd_addr_id  in  5 each  register addresses.
- use_rs1_id, use_rs2_id  in  1 each  decoder source-usage flags.
- RegDst_id, Jump_id, Branch_id, MemRead_id, MemtoReg_id, MemWrite_id, ALUSrc1_id, RegWrite_id, JALorJALR_id  in  1 each  decoder controls.
- ALUOp_id  in  7;  ALUSrc2_id  in  2;  BE_id  in  4;  Concat_control_id  in  3  decoder controls.
- flush_ex  in  1  EX redirect (taken branch/jump); the ID instruction must not enter EX.
- hold_ex  in  1  downstream freeze; EX contents must not change.
- *_ex  out  same widths as every *_id input above, including valid_ex  registered EX copies.
- stall_if_id  out  1  combinational; PC and IF/ID must hold this cycle.
- bubble_cnt  out  16  saturating count of load-use bubbles inserted.

## Operation
- Hazard detection, combinational:
  - load_use = valid_id & valid_ex & MemRead_ex & RegWrite_ex & (rd_addr_ex != 0) & ((use_rs1_id & rs1_addr_id == rd_addr_ex) | (use_rs2_id & rs2_addr_id == rd_addr_ex)).
  - MemRead_ex & RegWrite_ex selects loads only. Stores assert MemRead with RegWrite=0 and never trigger a hazard.
- stall_if_id = hold_ex | (load_use & ~flush_ex).
- Per-edge action, in priority order:
  - hold_ex=1: all *_ex registers and bubble_cnt keep their values, regardless of flush_ex or load_use. The EX stage keeps flush_ex asserted until hold_ex drops.
  - flush_ex=1: insert a bubble. bubble_cnt is unchanged.
  - load_use=1: insert a bubble. bubble_cnt increments, saturating at 16'hFFFF.
  - valid_id=0: insert a bubble. bubble_cnt is unchanged.
  - Otherwise: every *_id input is copied to its *_ex output, and valid_ex=1.
- Bubble definition:
  - valid_ex and all control outputs are forced to 0, including ALUOp_ex, BE_ex, Concat_control_ex and use_rs*_ex.
  - Data and address outputs are forced to 0.
  - A bubble never propagates X from the decoder.

## Timing
- Reset: while RSTn=0, every registered output is 0 immediately (asynchronous) and bubble_cnt=0. During reset stall_if_id = hold_ex.
- Reset deasserted mid-operation: the first rising edge after deassertion behaves as normal capture. No partial state survives reset.
- Latency: an *_id value presented before edge N appears on *_ex after edge N (1 cycle).
- Load-use sequence:
  - In cycle C, EX holds a load and ID holds a consumer: stall_if_id=1 in C.
  - Edge C+1 writes a bubble into EX, and the consumer remains in ID.
  - In cycle C+1, EX holds the bubble, so load_use=0 and stall_if_id drops unless hold_ex=1.
  - Edge C+2 moves the consumer into EX.
  - Exactly one bubble is inserted per load-use pair.
- Flush together with a hazard: the flush wins, stall_if_id=0, and the counter does not increment.
- The hazard path depends only on the current ID inputs and registered EX state, so there is no combinational loop through flush_ex or hold_ex.

## Test plan
- Reset: pulse RSTn low mid-stream with valid_ex=1 and bubble_cnt=7 -> all *_ex outputs go to 0 without waiting for CLK, and bubble_cnt=0.
- Load-use:
  - Stimulus: EX holds lw with MemRead=1, RegWrite=1, rd=5; ID holds add with rs1=5, use_rs1=1.
  - Required: stall_if_id=1 the same cycle.
  - After the next edge: valid_ex=0, RegWrite_ex=0, bubble_cnt=1, stall_if_id=0.
  - After the following edge: valid_ex=1 and rs1_addr_ex=5.
- No false hazards, each giving stall_if_id=0 and bubble_cnt unchanged:
  - Store in EX (MemRead=1, RegWrite=0, rd field=5) with ID rs1=5.
  - Load in EX with rd=0 and ID rs1=0.
  - I-type in ID with use_rs2=0 whose rs2 field equals rd_ex.
- Flush priority: load_use condition true and flush_ex=1 in the same cycle -> stall_if_id=0, the next edge gives valid_ex=0, and bubble_cnt is unchanged.
- Hold: hold_ex=1 for 3 cycles while ID inputs change -> *_ex outputs stay constant, stall_if_id=1 each cycle, and bubble_cnt is unchanged.
- Saturation: preload bubble_cnt to 16'hFFFE via 65534 hazards, then force 3 more hazards -> bubble_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder controls and operands in, registered EX copies,
// the IF/ID stall and the load-use bubble counter out.
interface id_ex_stage_if;
  logic        valid_id;
  logic [31:0] pc_id;
  logic [31:0] rs1_data_id;
  logic [31:0] rs2_data_id;
  logic [31:0] imm_id;
  logic [4:0]  rs1_addr_id;
  logic [4:0]  rs2_addr_id;
  logic [4:0]  rd_addr_id;
  logic        use_rs1_id;
  logic        use_rs2_id;
  logic        RegDst_id;
  logic        Jump_id;
  logic        Branch_id;
  logic        MemRead_id;
  logic        MemtoReg_id;
  logic        MemWrite_id;
  logic        ALUSrc1_id;
  logic        RegWrite_id;
  logic        JALorJALR_id;
  logic [6:0]  ALUOp_id;
  logic [1:0]  ALUSrc2_id;
  logic [3:0]  BE_id;
  logic [2:0]  Concat_control_id;

  logic        flush_ex;
  logic        hold_ex;

  logic        valid_ex;
  logic [31:0] pc_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [31:0] imm_ex;
  logic [4:0]  rs1_addr_ex;
  logic [4:0]  rs2_addr_ex;
  logic [4:0]  rd_addr_ex;
  logic        use_rs1_ex;
  logic        use_rs2_ex;
  logic        RegDst_ex;
  logic        Jump_ex;
  logic        Branch_ex;
  logic        MemRead_ex;
  logic        MemtoReg_ex;
  logic        MemWrite_ex;
  logic        ALUSrc1_ex;
  logic        RegWrite_ex;
  logic        JALorJALR_ex;
  logic [6:0]  ALUOp_ex;
  logic [1:0]  ALUSrc2_ex;
  logic [3:0]  BE_ex;
  logic [2:0]  Concat_control_ex;

  logic        stall_if_id;
  logic [15:0] bubble_cnt;

  modport master (
    output valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           rs1_addr_id, rs2_addr_id, rd_addr_id, use_rs1_id, use_rs2_id,
           RegDst_id, Jump_id, Branch_id, MemRead_id, MemtoReg_id, MemWrite_id,
           ALUSrc1_id, RegWrite_id, JALorJALR_id, ALUOp_id, ALUSrc2_id, BE_id,
           Concat_control_id, flush_ex, hold_ex,
    input  valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           rs1_addr_ex, rs2_addr_ex, rd_addr_ex, use_rs1_ex, use_rs2_ex,
           RegDst_ex, Jump_ex, Branch_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex,
           ALUSrc1_ex, RegWrite_ex, JALorJALR_ex, ALUOp_ex, ALUSrc2_ex, BE_ex,
           Concat_control_ex, stall_if_id, bubble_cnt
  );

  modport slave (
    input  valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           rs1_addr_id, rs2_addr_id, rd_addr_id, use_rs1_id, use_rs2_id,
           RegDst_id, Jump_id, Branch_id, MemRead_id, MemtoReg_id, MemWrite_id,
           ALUSrc1_id, RegWrite_id, JALorJALR_id, ALUOp_id, ALUSrc2_id, BE_id,
           Concat_control_id, flush_ex, hold_ex,
    output valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           rs1_addr_ex, rs2_addr_ex, rd_addr_ex, use_rs1_ex, use_rs2_ex,
           RegDst_ex, Jump_ex, Branch_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex,
           ALUSrc1_ex, RegWrite_ex, JALorJALR_ex, ALUOp_ex, ALUSrc2_ex, BE_ex,
           Concat_control_ex, stall_if_id, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage (
  input  logic          CLK,
  input  logic          RSTn,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        use_rs1;
    logic        use_rs2;
    logic        reg_dst;
    logic        jump;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src1;
    logic        reg_write;
    logic        jal_or_jalr;
    logic [6:0]  alu_op;
    logic [1:0]  alu_src2;
    logic [3:0]  be;
    logic [2:0]  concat_ctrl;
  } stage_t;

  stage_t      id_bundle;
  stage_t      ex_q, ex_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        rs1_hit, rs2_hit, ex_is_load, load_use;

  assign id_bundle = '{
    valid:       bus.valid_id,
    pc:          bus.pc_id,
    rs1_data:    bus.rs1_data_id,
    rs2_data:    bus.rs2_data_id,
    imm:         bus.imm_id,
    rs1_addr:    bus.rs1_addr_id,
    rs2_addr:    bus.rs2_addr_id,
    rd_addr:     bus.rd_addr_id,
    use_rs1:     bus.use_rs1_id,
    use_rs2:     bus.use_rs2_id,
    reg_dst:     bus.RegDst_id,
    jump:        bus.Jump_id,
    branch:      bus.Branch_id,
    mem_read:    bus.MemRead_id,
    mem_to_reg:  bus.MemtoReg_id,
    mem_write:   bus.MemWrite_id,
    alu_src1:    bus.ALUSrc1_id,
    reg_write:   bus.RegWrite_id,
    jal_or_jalr: bus.JALorJALR_id,
    alu_op:      bus.ALUOp_id,
    alu_src2:    bus.ALUSrc2_id,
    be:          bus.BE_id,
    concat_ctrl: bus.Concat_control_id
  };

  // Only registered EX state and ID inputs feed the hazard, so flush/hold never loop back.
  assign ex_is_load = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd_addr != 5'd0);
  assign rs1_hit    = bus.use_rs1_id & (bus.rs1_addr_id == ex_q.rd_addr);
  assign rs2_hit    = bus.use_rs2_id & (bus.rs2_addr_id == ex_q.rd_addr);
  assign load_use   = bus.valid_id & ex_is_load & (rs1_hit | rs2_hit);

  assign bus.stall_if_id = bus.hold_ex | (load_use & ~bus.flush_ex);

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.hold_ex) begin
      if (bus.flush_ex) begin
        ex_d = '0;
      end else if (load_use) begin
        ex_d         = '0;
        bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
      end else if (!bus.valid_id) begin
        ex_d = '0;
      end else begin
        ex_d       = id_bundle;
        ex_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_q         <= '0;
      bubble_cnt_q <= 16'd0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.valid_ex          = ex_q.valid;
  assign bus.pc_ex             = ex_q.pc;
  assign bus.rs1_data_ex       = ex_q.rs1_data;
  assign bus.rs2_data_ex       = ex_q.rs2_data;
  assign bus.imm_ex            = ex_q.imm;
  assign bus.rs1_addr_ex       = ex_q.rs1_addr;
  assign bus.rs2_addr_ex       = ex_q.rs2_addr;
  assign bus.rd_addr_ex        = ex_q.rd_addr;
  assign bus.use_rs1_ex        = ex_q.use_rs1;
  assign bus.use_rs2_ex        = ex_q.use_rs2;
  assign bus.RegDst_ex         = ex_q.reg_dst;
  assign bus.Jump_ex           = ex_q.jump;
  assign bus.Branch_ex         = ex_q.branch;
  assign bus.MemRead_ex        = ex_q.mem_read;
  assign bus.MemtoReg_ex       = ex_q.mem_to_reg;
  assign bus.MemWrite_ex       = ex_q.mem_write;
  assign bus.ALUSrc1_ex        = ex_q.alu_src1;
  assign bus.RegWrite_ex       = ex_q.reg_write;
  assign bus.JALorJALR_ex      = ex_q.jal_or_jalr;
  assign bus.ALUOp_ex          = ex_q.alu_op;
  assign bus.ALUSrc2_ex        = ex_q.alu_src2;
  assign bus.BE_ex             = ex_q.be;
  assign bus.Concat_control_ex = ex_q.concat_ctrl;
  assign bus.bubble_cnt        = bubble_cnt_q;

endmodule
